// File: rtl/j1708_rx_buffer_if.sv
// Framer-to-buffer and buffer-to-consumer signal bundle for the J1708 receive buffer.
// The buffer takes the slave side; the framer/CPU side (or a bench) takes the master side.
interface j1708_rx_buffer_if;
    logic [7:0] in_byte;
    logic       in_byte_valid;
    logic       in_msg_end;
    logic       in_msg_abort;

    logic       rx_message_byte_read;
    logic [7:0] rx_message_byte;
    logic       rx_message_byte_valid;
    logic       rx_message_new_byte;

    logic       rx_message_length_read;
    logic [7:0] rx_message_length;
    logic       rx_message_length_valid;
    logic       rx_message_length_exist;

    logic [7:0] dropped_count;

    modport slave (
        input  in_byte, in_byte_valid, in_msg_end, in_msg_abort,
        input  rx_message_byte_read, rx_message_length_read,
        output rx_message_byte, rx_message_byte_valid, rx_message_new_byte,
        output rx_message_length, rx_message_length_valid, rx_message_length_exist,
        output dropped_count
    );

    modport master (
        output in_byte, in_byte_valid, in_msg_end, in_msg_abort,
        output rx_message_byte_read, rx_message_length_read,
        input  rx_message_byte, rx_message_byte_valid, rx_message_new_byte,
        input  rx_message_length, rx_message_length_valid, rx_message_length_exist,
        input  dropped_count
    );
endinterface

// File: rtl/j1708_rx_buffer.sv
// J1708 message receive buffer: bytes are written speculatively and become visible
// to the reader only when the whole message commits, together with its length.
module j1708_rx_buffer #(
    parameter int DATA_AW     = 8,
    parameter int LEN_AW      = 4,
    parameter int MAX_MSG_LEN = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    j1708_rx_buffer_if.slave   bus
);
    localparam logic [DATA_AW:0] BYTE_DEPTH = {1'b1, {DATA_AW{1'b0}}};
    localparam logic [LEN_AW:0]  LEN_DEPTH  = {1'b1, {LEN_AW{1'b0}}};
    localparam logic [7:0]       MAX_LEN    = 8'(MAX_MSG_LEN);

    logic [7:0] mem  [0:(1<<DATA_AW)-1];
    logic [7:0] lmem [0:(1<<LEN_AW)-1];

    logic [DATA_AW:0] wr_ptr_q, wr_ptr_d;
    logic [DATA_AW:0] commit_ptr_q, commit_ptr_d;
    logic [DATA_AW:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_AW:0]  lwr_q, lwr_d;
    logic [LEN_AW:0]  lrd_q, lrd_d;
    logic [7:0]       msg_cnt_q, msg_cnt_d;
    logic             drop_q, drop_d;
    logic [7:0]       dropped_q, dropped_d;

    logic             new_byte_q, len_exist_q;
    logic [7:0]       byte_q, len_q;
    logic             byte_vld_q, len_vld_q;

    logic             byte_full, len_full;
    logic             rd_fire, len_fire;
    logic             byte_we, len_we;
    logic [DATA_AW:0] wr_next;
    logic [7:0]       cnt_next;
    logic             drop_next;
    logic [7:0]       dropped_inc;

    // Fullness is judged against the pre-read pointers, so a same-cycle pop does not make room.
    assign byte_full   = (wr_ptr_q - rd_ptr_q) == BYTE_DEPTH;
    assign len_full    = (lwr_q - lrd_q) == LEN_DEPTH;
    assign rd_fire     = enable && bus.rx_message_byte_read && new_byte_q;
    assign len_fire    = enable && bus.rx_message_length_read && len_exist_q;
    assign dropped_inc = (dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        lwr_d        = lwr_q;
        lrd_d        = lrd_q;
        msg_cnt_d    = msg_cnt_q;
        drop_d       = drop_q;
        dropped_d    = dropped_q;
        byte_we      = 1'b0;
        len_we       = 1'b0;
        wr_next      = wr_ptr_q;
        cnt_next     = msg_cnt_q;
        drop_next    = drop_q;

        if (!enable) begin
            wr_ptr_d     = '0;
            commit_ptr_d = '0;
            rd_ptr_d     = '0;
            lwr_d        = '0;
            lrd_d        = '0;
            msg_cnt_d    = '0;
            drop_d       = 1'b0;
        end else begin
            if (rd_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (len_fire) lrd_d    = lrd_q + 1'b1;

            if (bus.in_msg_abort) begin
                wr_ptr_d  = commit_ptr_q;
                msg_cnt_d = '0;
                drop_d    = 1'b0;
                if (msg_cnt_q != 8'd0 || drop_q) dropped_d = dropped_inc;
            end else begin
                // The incoming byte is resolved first so a coincident end sees it as the last byte.
                if (bus.in_byte_valid && !drop_q) begin
                    if (byte_full || msg_cnt_q == MAX_LEN) begin
                        drop_next = 1'b1;
                        wr_next   = commit_ptr_q;
                    end else begin
                        byte_we  = 1'b1;
                        wr_next  = wr_ptr_q + 1'b1;
                        cnt_next = msg_cnt_q + 8'd1;
                    end
                end
                wr_ptr_d  = wr_next;
                msg_cnt_d = cnt_next;
                drop_d    = drop_next;

                if (bus.in_msg_end) begin
                    if (drop_next) begin
                        dropped_d = dropped_inc;
                        drop_d    = 1'b0;
                        msg_cnt_d = '0;
                        wr_ptr_d  = commit_ptr_q;
                    end else if (cnt_next == 8'd0) begin
                        msg_cnt_d = '0;
                    end else if (len_full) begin
                        wr_ptr_d  = commit_ptr_q;
                        dropped_d = dropped_inc;
                        msg_cnt_d = '0;
                    end else begin
                        commit_ptr_d = wr_next;
                        len_we       = 1'b1;
                        lwr_d        = lwr_q + 1'b1;
                        msg_cnt_d    = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_we) mem[wr_ptr_q[DATA_AW-1:0]] <= bus.in_byte;
        if (len_we)  lmem[lwr_q[LEN_AW-1:0]]   <= cnt_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            lwr_q        <= '0;
            lrd_q        <= '0;
            msg_cnt_q    <= '0;
            drop_q       <= 1'b0;
            dropped_q    <= '0;
            new_byte_q   <= 1'b0;
            len_exist_q  <= 1'b0;
            byte_q       <= '0;
            len_q        <= '0;
            byte_vld_q   <= 1'b0;
            len_vld_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lwr_q        <= lwr_d;
            lrd_q        <= lrd_d;
            msg_cnt_q    <= msg_cnt_d;
            drop_q       <= drop_d;
            dropped_q    <= dropped_d;
            // Flags track next-state pointers so a pop is reflected on the same cycle as its data.
            new_byte_q   <= rd_ptr_d != commit_ptr_d;
            len_exist_q  <= lwr_d != lrd_d;
            byte_vld_q   <= rd_fire;
            len_vld_q    <= len_fire;
            if (rd_fire)  byte_q <= mem[rd_ptr_q[DATA_AW-1:0]];
            if (len_fire) len_q  <= lmem[lrd_q[LEN_AW-1:0]];
        end
    end

    assign bus.rx_message_byte         = byte_q;
    assign bus.rx_message_byte_valid   = byte_vld_q;
    assign bus.rx_message_new_byte     = new_byte_q;
    assign bus.rx_message_length       = len_q;
    assign bus.rx_message_length_valid = len_vld_q;
    assign bus.rx_message_length_exist = len_exist_q;
    assign bus.dropped_count           = dropped_q;
endmodule

// File: tb/tb_j1708_rx_buffer.sv
// Scoreboard bench for j1708_rx_buffer: stimulus pushes expected committed bytes/lengths,
// a negedge monitor pops and compares on every valid strobe.
module tb_j1708_rx_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;

    j1708_rx_buffer_if bus();

    j1708_rx_buffer #(.DATA_AW(8), .LEN_AW(4), .MAX_MSG_LEN(21)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_lens[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: any strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_message_byte_valid) begin
                if (exp_bytes.size() == 0) chk("byte_unexpected", int'(bus.rx_message_byte), -1);
                else chk("byte_data", int'(bus.rx_message_byte), int'(exp_bytes.pop_front()));
            end
            if (bus.rx_message_length_valid) begin
                if (exp_lens.size() == 0) chk("len_unexpected", int'(bus.rx_message_length), -1);
                else chk("len_data", int'(bus.rx_message_length), int'(exp_lens.pop_front()));
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic bv, input logic me, input logic ab);
        bus.in_byte = b; bus.in_byte_valid = bv; bus.in_msg_end = me; bus.in_msg_abort = ab;
        @(negedge clk);
        bus.in_byte_valid = 1'b0; bus.in_msg_end = 1'b0; bus.in_msg_abort = 1'b0;
    endtask

    task automatic read_bytes(input int n);
        bus.rx_message_byte_read = 1'b1;
        repeat (n) @(negedge clk);
        bus.rx_message_byte_read = 1'b0;
    endtask

    task automatic read_lens(input int n);
        bus.rx_message_length_read = 1'b1;
        repeat (n) @(negedge clk);
        bus.rx_message_length_read = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_byte = 8'h00; bus.in_byte_valid = 1'b0; bus.in_msg_end = 1'b0; bus.in_msg_abort = 1'b0;
        bus.rx_message_byte_read = 1'b0; bus.rx_message_length_read = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_new_byte", int'(bus.rx_message_new_byte), 0);
        chk("rst_len_exist", int'(bus.rx_message_length_exist), 0);
        chk("rst_dropped", int'(bus.dropped_count), 0);
        chk("rst_byte_valid", int'(bus.rx_message_byte_valid), 0);

        // Basic 3-byte message
        drive(8'h80, 1, 0, 0); drive(8'h01, 1, 0, 0); drive(8'h02, 1, 0, 0);
        chk("spec_hidden", int'(bus.rx_message_new_byte), 0);
        drive(8'h00, 0, 1, 0);
        chk("m1_new_byte", int'(bus.rx_message_new_byte), 1);
        chk("m1_len_exist", int'(bus.rx_message_length_exist), 1);
        exp_lens.push_back(8'd3);
        exp_bytes.push_back(8'h80); exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h02);
        read_lens(1);
        read_bytes(3);
        @(negedge clk);
        chk("m1_new_byte_after", int'(bus.rx_message_new_byte), 0);
        chk("m1_len_exist_after", int'(bus.rx_message_length_exist), 0);

        // Abort after 5 bytes, then a clean 2-byte message
        for (int i = 0; i < 5; i++) drive(8'(8'h30 + i), 1, 0, 0);
        drive(8'h00, 0, 0, 1);
        chk("abort_new_byte", int'(bus.rx_message_new_byte), 0);
        chk("abort_dropped", int'(bus.dropped_count), 1);
        drive(8'h11, 1, 0, 0); drive(8'h22, 1, 0, 0); drive(8'h00, 0, 1, 0);
        exp_lens.push_back(8'd2); exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h22);
        read_lens(1);
        read_bytes(2);

        // Oversize 22-byte message dropped, 21-byte message accepted
        for (int i = 0; i < 22; i++) drive(8'(8'hC0 + i), 1, 0, 0);
        drive(8'h00, 0, 1, 0);
        chk("long_new_byte", int'(bus.rx_message_new_byte), 0);
        chk("long_dropped", int'(bus.dropped_count), 2);
        for (int i = 0; i < 21; i++) begin
            drive(8'(8'h40 + i), 1, 0, 0);
            exp_bytes.push_back(8'(8'h40 + i));
        end
        drive(8'h00, 0, 1, 0);
        exp_lens.push_back(8'd21);
        chk("max_len_exist", int'(bus.rx_message_length_exist), 1);
        read_lens(1);
        read_bytes(21);

        // Length FIFO overflow: 17 two-byte messages from a fresh reset
        @(negedge clk);
        do_reset();
        chk("rst2_dropped", int'(bus.dropped_count), 0);
        for (int m = 0; m < 17; m++) begin
            drive(8'(2 * m), 1, 0, 0);
            drive(8'(2 * m + 1), 1, 1, 0);
            if (m < 16) begin
                exp_bytes.push_back(8'(2 * m)); exp_bytes.push_back(8'(2 * m + 1));
                exp_lens.push_back(8'd2);
            end
        end
        chk("lfull_dropped", int'(bus.dropped_count), 1);
        chk("lfull_len_exist", int'(bus.rx_message_length_exist), 1);
        read_lens(16);
        @(negedge clk);
        chk("lfull_len_drained", int'(bus.rx_message_length_exist), 0);
        chk("lfull_bytes_left", int'(bus.rx_message_new_byte), 1);
        read_bytes(32);
        @(negedge clk);
        chk("lfull_bytes_drained", int'(bus.rx_message_new_byte), 0);

        // Coincident last byte/end, then continuous reading across a commit
        drive(8'hA1, 1, 0, 0); drive(8'hA2, 1, 1, 0);
        exp_lens.push_back(8'd2); exp_bytes.push_back(8'hA1); exp_bytes.push_back(8'hA2);
        bus.rx_message_byte_read = 1'b1;
        drive(8'hB1, 1, 0, 0); drive(8'hB2, 1, 0, 0); drive(8'hB3, 1, 1, 0);
        exp_lens.push_back(8'd3);
        exp_bytes.push_back(8'hB1); exp_bytes.push_back(8'hB2); exp_bytes.push_back(8'hB3);
        repeat (6) @(negedge clk);
        bus.rx_message_byte_read = 1'b0;
        chk("cont_bytes_drained", exp_bytes.size(), 0);
        read_lens(2);

        // Flush via enable low with a committed message and a partial one pending
        drive(8'hC1, 1, 0, 0); drive(8'hC2, 1, 1, 0);
        drive(8'hD1, 1, 0, 0); drive(8'hD2, 1, 0, 0);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        chk("flush_new_byte", int'(bus.rx_message_new_byte), 0);
        chk("flush_len_exist", int'(bus.rx_message_length_exist), 0);
        chk("flush_dropped_kept", int'(bus.dropped_count), 1);
        drive(8'hE1, 1, 0, 0); drive(8'hE2, 1, 1, 0);
        exp_lens.push_back(8'd2); exp_bytes.push_back(8'hE1); exp_bytes.push_back(8'hE2);
        read_lens(1);
        read_bytes(2);

        repeat (3) @(negedge clk);
        chk("final_bytes_pending", exp_bytes.size(), 0);
        chk("final_lens_pending", exp_lens.size(), 0);
        chk("final_new_byte", int'(bus.rx_message_new_byte), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
